ch_capture: RTL and testbench

Record-side counterpart of the channel playback unit: samples a 1-bit channel input on a sample strobe, packs the samples LSB-first into 32-bit words, and writes them into the channel BRAM through its 32-bit port B. Bit address k maps to word k[19:5], lane k[4:0], the same layout the playback unit reads back. The block sits beside the playback unit in the channel tile, driven by the same GPIO register bank on the AXI clock.

---
 rtl/ch_pkg.sv | 21 ++
 rtl/ch_capture_if.sv | 36 +++
 rtl/ch_word_packer.sv | 68 ++++++
 rtl/ch_capture.sv | 94 +++++++++
 tb/tb_ch_capture.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ch_pkg.sv
// Shared types and constants for the channel capture path.
package ch_pkg;

  localparam int LANE_BITS      = 5;
  localparam int WORD_WIDTH     = 32;
  localparam int N_ADDR_BITS    = 20;
  localparam int WORD_ADDR_BITS = N_ADDR_BITS - LANE_BITS;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FLUSH,
    DONE
  } state_t;

  // Start addresses are word aligned: the lane field is forced to zero.
  function automatic logic [N_ADDR_BITS-1:0] align_word(input logic [N_ADDR_BITS-1:0] a);
    return {a[N_ADDR_BITS-1:LANE_BITS], {LANE_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/ch_capture_if.sv
// GPIO control, sample input and BRAM port-B bundle of the capture unit.
interface ch_capture_if;
  import ch_pkg::*;

  logic [N_ADDR_BITS-1:0]    i_gpio_set_ram_addr;
  logic                      i_gpio_write_addr;
  logic [N_ADDR_BITS-1:0]    i_gpio_stop_addr;
  logic                      i_gpio_write_stop_addr;
  logic                      i_gpio_capture_en;
  logic                      i_gpio_loop_capture;
  logic                      i_sample_strobe;
  logic                      ch_in;
  logic [N_ADDR_BITS-1:0]    o_gpio_addr_readback;
  logic                      o_gpio_capture_done;
  logic                      o_bram_en;
  logic                      o_bram_we;
  logic [WORD_ADDR_BITS-1:0] o_bram_addr;
  logic [WORD_WIDTH-1:0]     o_bram_din;

  modport master (
    output i_gpio_set_ram_addr, i_gpio_write_addr, i_gpio_stop_addr,
           i_gpio_write_stop_addr, i_gpio_capture_en, i_gpio_loop_capture,
           i_sample_strobe, ch_in,
    input  o_gpio_addr_readback, o_gpio_capture_done, o_bram_en, o_bram_we,
           o_bram_addr, o_bram_din
  );

  modport slave (
    input  i_gpio_set_ram_addr, i_gpio_write_addr, i_gpio_stop_addr,
           i_gpio_write_stop_addr, i_gpio_capture_en, i_gpio_loop_capture,
           i_sample_strobe, ch_in,
    output o_gpio_addr_readback, o_gpio_capture_done, o_bram_en, o_bram_we,
           o_bram_addr, o_bram_din
  );

endinterface

// File: rtl/ch_word_packer.sv
// Packs sampled bits LSB-first into a word and hands finished words to a
// separate write register so back-to-back strobes never stall.
module ch_word_packer
  import ch_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int WORD_ADDR_BITS = 15
) (
  input  logic                      clk,
  input  logic                      s_axi_reset,
  input  logic                      clear,
  input  logic                      sample,
  input  logic                      bit_in,
  input  logic                      last,
  input  logic                      abort,
  input  logic [LANE_BITS-1:0]      lane,
  input  logic [WORD_ADDR_BITS-1:0] word_addr,
  output logic                      vld_p1,
  output logic [WORD_ADDR_BITS-1:0] addr_p1,
  output logic [WORD_WIDTH-1:0]     din_p1
);

  logic [WORD_WIDTH-1:0] word_p0;
  logic [WORD_WIDTH-1:0] word_ins;
  logic                  any_p0;
  logic                  full;

  assign word_ins = word_p0 | (WORD_WIDTH'(bit_in) << lane);
  assign full     = &lane;

  // Assembly register (p0) feeding the one-cycle write register (p1)
  always_ff @(posedge clk) begin
    if (!s_axi_reset) begin
      word_p0 <= '0;
      any_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      din_p1  <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (clear) begin
        word_p0 <= '0;
        any_p0  <= 1'b0;
      end else if (sample) begin
        if (full || last) begin
          vld_p1  <= 1'b1;
          addr_p1 <= word_addr;
          din_p1  <= word_ins;
          word_p0 <= '0;
          any_p0  <= 1'b0;
        end else begin
          word_p0 <= word_ins;
          any_p0  <= 1'b1;
        end
      end else if (abort) begin
        // A partially filled word is still written; an empty one is dropped.
        if (any_p0) begin
          vld_p1  <= 1'b1;
          addr_p1 <= word_addr;
          din_p1  <= word_p0;
        end
        word_p0 <= '0;
        any_p0  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ch_capture.sv
// Channel record unit: GPIO-controlled capture FSM and bit pointer, with the
// word packer writing finished words into the channel BRAM port B.
module ch_capture
  import ch_pkg::*;
#(
  parameter int N_ADDR_BITS    = 20,
  parameter int WORD_WIDTH     = 32,
  parameter int WORD_ADDR_BITS = 15
) (
  input logic         s_axi_clk,
  input logic         s_axi_reset,
  ch_capture_if.slave bus
);

  state_t                 state, state_nx;
  logic [N_ADDR_BITS-1:0] start_addr;
  logic [N_ADDR_BITS-1:0] stop_addr;
  logic [N_ADDR_BITS-1:0] ptr;
  logic                   stop_hit;
  logic                   in_idle;
  logic                   accept;
  logic                   last;
  logic                   abort;

  assign in_idle = (state == IDLE);
  assign accept  = (state == CAPTURE) && bus.i_gpio_capture_en && bus.i_sample_strobe;
  assign last    = accept && (ptr == stop_addr);
  assign abort   = (state == CAPTURE) && !bus.i_gpio_capture_en;

  // State register, address registers, bit pointer and stop-reached flag
  always_ff @(posedge s_axi_clk) begin
    if (!s_axi_reset) begin
      state      <= IDLE;
      start_addr <= '0;
      stop_addr  <= '0;
      ptr        <= '0;
      stop_hit   <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_idle) begin
        stop_hit <= 1'b0;
        if (bus.i_gpio_write_stop_addr) stop_addr <= bus.i_gpio_stop_addr;
        if (bus.i_gpio_write_addr) begin
          start_addr <= align_word(bus.i_gpio_set_ram_addr);
          ptr        <= align_word(bus.i_gpio_set_ram_addr);
        end else begin
          ptr <= start_addr;
        end
      end else if (accept) begin
        if (last && bus.i_gpio_loop_capture) begin
          ptr <= start_addr;
        end else begin
          ptr <= ptr + 1'b1;
          if (last) stop_hit <= 1'b1;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.i_gpio_capture_en) state_nx = CAPTURE;
      CAPTURE: if (abort || (last && !bus.i_gpio_loop_capture)) state_nx = FLUSH;
      FLUSH:   state_nx = stop_hit ? DONE : IDLE;
      DONE:    if (!bus.i_gpio_capture_en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  ch_word_packer #(
    .WORD_WIDTH     (WORD_WIDTH),
    .WORD_ADDR_BITS (WORD_ADDR_BITS)
  ) u_packer (
    .clk         (s_axi_clk),
    .s_axi_reset (s_axi_reset),
    .clear       (in_idle),
    .sample      (accept),
    .bit_in      (bus.ch_in),
    .last        (last),
    .abort       (abort),
    .lane        (ptr[LANE_BITS-1:0]),
    .word_addr   (ptr[N_ADDR_BITS-1:LANE_BITS]),
    .vld_p1      (bus.o_bram_en),
    .addr_p1     (bus.o_bram_addr),
    .din_p1      (bus.o_bram_din)
  );

  assign bus.o_bram_we            = bus.o_bram_en;
  assign bus.o_gpio_addr_readback = ptr;
  assign bus.o_gpio_capture_done  = (state == DONE);

endmodule

// File: tb/tb_ch_capture.sv
// Bench for ch_capture: behavioural model of the capture rules, a per-cycle
// compare process, directed scenarios with literal expectations, random runs.
module tb_ch_capture;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ch_capture_if bus();

  ch_capture dut (
    .s_axi_clk   (clk),
    .s_axi_reset (rst_n),
    .bus         (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Observed write log and done tracking
  int          q_addr[$];
  logic [31:0] q_din[$];
  int          q_cyc[$];
  int          done_seen = 0;
  int          done_rise_cyc = -1;
  logic        done_prev = 1'b0;

  // Behavioural model state
  int          m_phase = 0;      // 0 idle, 1 capturing, 2 flushing, 3 finished
  logic [19:0] m_start = '0;
  logic [19:0] m_stop = '0;
  logic [19:0] m_ptr = '0;
  logic [31:0] m_acc = '0;
  int          m_n = 0;
  bit          m_hit = 0;
  bit          e_en = 0;
  int          e_addr = 0;
  logic [31:0] e_din = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: what the outputs must be after each clock edge
  always @(posedge clk) begin
    e_en = 0;
    if (!rst_n) begin
      m_phase = 0; m_start = 0; m_stop = 0; m_ptr = 0;
      m_acc = 0; m_n = 0; m_hit = 0; e_addr = 0; e_din = 0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.i_gpio_write_addr) m_start = (bus.i_gpio_set_ram_addr / 32) * 32;
          if (bus.i_gpio_write_stop_addr) m_stop = bus.i_gpio_stop_addr;
          m_ptr = m_start; m_acc = 0; m_n = 0; m_hit = 0;
          if (bus.i_gpio_capture_en) m_phase = 1;
        end
        1: begin
          if (!bus.i_gpio_capture_en) begin
            if (m_n > 0) begin e_en = 1; e_addr = m_ptr / 32; e_din = m_acc; end
            m_acc = 0; m_n = 0; m_phase = 2;
          end else if (bus.i_sample_strobe) begin
            m_acc[m_ptr % 32] = bus.ch_in;
            m_n++;
            if (m_ptr == m_stop || (m_ptr % 32) == 31) begin
              e_en = 1; e_addr = m_ptr / 32; e_din = m_acc; m_acc = 0; m_n = 0;
            end
            if (m_ptr == m_stop && bus.i_gpio_loop_capture) m_ptr = m_start;
            else begin
              if (m_ptr == m_stop) begin m_hit = 1; m_phase = 2; end
              m_ptr = 20'((m_ptr + 1) % (1 << 20));
            end
          end
        end
        2: m_phase = m_hit ? 3 : 0;
        default: if (!bus.i_gpio_capture_en) m_phase = 0;
      endcase
    end
  end

  // Compare process: every cycle, shortly after the active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      chk("bram_en", 32'(bus.o_bram_en), 32'(e_en));
      chk("bram_we", 32'(bus.o_bram_we), 32'(e_en));
      if (e_en) begin
        chk("bram_addr", 32'(bus.o_bram_addr), 32'(e_addr));
        chk("bram_din", bus.o_bram_din, e_din);
      end
      chk("readback", 32'(bus.o_gpio_addr_readback), 32'(m_ptr));
      chk("done", 32'(bus.o_gpio_capture_done), 32'(m_phase == 3));
      if (bus.o_bram_en) begin
        q_addr.push_back(int'(bus.o_bram_addr));
        q_din.push_back(bus.o_bram_din);
        q_cyc.push_back(cyc);
      end
      if (bus.o_gpio_capture_done) done_seen++;
      if (bus.o_gpio_capture_done && !done_prev) done_rise_cyc = cyc;
      done_prev = bus.o_gpio_capture_done;
    end
  end

  task automatic clear_log();
    q_addr.delete(); q_din.delete(); q_cyc.delete();
    done_seen = 0; done_rise_cyc = -1;
  endtask

  task automatic setup(input logic [19:0] s, input logic [19:0] e, input bit lp);
    @(negedge clk);
    bus.i_gpio_set_ram_addr = s; bus.i_gpio_stop_addr = e;
    bus.i_gpio_write_addr = 1; bus.i_gpio_write_stop_addr = 1;
    bus.i_gpio_loop_capture = lp;
    @(negedge clk);
    bus.i_gpio_write_addr = 0; bus.i_gpio_write_stop_addr = 0;
    @(negedge clk);
    clear_log();
  endtask

  // Raise capture_en and let the rising cycle pass with no strobe
  task automatic start_cap();
    bus.i_gpio_capture_en = 1;
    @(negedge clk);
  endtask

  // mode 0: ch = i[0] (i from 1), 1: ch = 1, 2: ones on even words, 3: random
  task automatic drive(input int n, input int mode);
    for (int i = 1; i <= n; i++) begin
      bus.i_sample_strobe = 1;
      case (mode)
        0: bus.ch_in = i[0];
        1: bus.ch_in = 1;
        2: bus.ch_in = (((i - 1) / 32) % 2) == 0;
        default: bus.ch_in = 1'($urandom);
      endcase
      @(negedge clk);
    end
    bus.i_sample_strobe = 0;
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (!bus.o_gpio_capture_done && c < 100) begin @(negedge clk); c++; end
    checks++;
    if (!bus.o_gpio_capture_done) begin
      errors++;
      $display("FAIL %s: done not seen within 100 cycles", name);
    end
  endtask

  task automatic stop_cap();
    bus.i_gpio_capture_en = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [19:0] s, e;
    bit lp;
    bus.i_gpio_set_ram_addr = 0; bus.i_gpio_write_addr = 0;
    bus.i_gpio_stop_addr = 0; bus.i_gpio_write_stop_addr = 0;
    bus.i_gpio_capture_en = 0; bus.i_gpio_loop_capture = 0;
    bus.i_sample_strobe = 0; bus.ch_in = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_bram_en", 32'(bus.o_bram_en), 0);
    chk("rst_readback", 32'(bus.o_gpio_addr_readback), 0);
    chk("rst_din", bus.o_bram_din, 0);
    rst_n = 1;

    // Reset in the middle of a capture
    setup(20'h100, 20'h1FF, 0);
    start_cap();
    drive(10, 3);
    rst_n = 0; bus.i_gpio_capture_en = 0;
    @(negedge clk);
    chk("midrst_bram_en", 32'(bus.o_bram_en), 0);
    chk("midrst_readback", 32'(bus.o_gpio_addr_readback), 0);
    chk("midrst_done", 32'(bus.o_gpio_capture_done), 0);
    chk("midrst_addr", 32'(bus.o_bram_addr), 0);
    chk("midrst_din", bus.o_bram_din, 0);
    chk("midrst_writes", q_addr.size(), 0);
    rst_n = 1;
    @(negedge clk);

    // Two full words, alternating bits
    setup(20'h0, 20'd63, 0);
    start_cap();
    drive(64, 0);
    wait_done("two_words");
    chk("two_words_n", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      chk("two_words_a0", q_addr[0], 0);
      chk("two_words_d0", q_din[0], 32'h5555_5555);
      chk("two_words_a1", q_addr[1], 1);
      chk("two_words_d1", q_din[1], 32'h5555_5555);
      chk("two_words_done_lat", done_rise_cyc, q_cyc[1] + 1);
    end
    stop_cap();

    // Short partial word ending at the stop address
    setup(20'h20, 20'h24, 0);
    start_cap();
    drive(5, 1);
    wait_done("short");
    chk("short_n", q_addr.size(), 1);
    if (q_addr.size() == 1) begin
      chk("short_a", q_addr[0], 1);
      chk("short_d", q_din[0], 32'h0000_001F);
    end
    stop_cap();

    // Pointer wraps through the top of the address space
    setup(20'hFFFE0, 20'h0001F, 0);
    start_cap();
    drive(64, 2);
    wait_done("wrap");
    chk("wrap_n", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      chk("wrap_a0", q_addr[0], 32'h7FFF);
      chk("wrap_d0", q_din[0], 32'hFFFF_FFFF);
      chk("wrap_a1", q_addr[1], 0);
      chk("wrap_d1", q_din[1], 32'h0);
    end
    stop_cap();

    // Loop mode, stopped by disabling capture
    setup(20'h0, 20'd31, 1);
    start_cap();
    drive(100, 1);
    stop_cap();
    chk("loop_n", q_addr.size(), 4);
    if (q_addr.size() == 4) begin
      for (int i = 0; i < 3; i++) begin
        chk("loop_a", q_addr[i], 0);
        chk("loop_d", q_din[i], 32'hFFFF_FFFF);
      end
      chk("loop_a3", q_addr[3], 0);
      chk("loop_d3", q_din[3], 32'h0000_000F);
    end
    chk("loop_done", done_seen, 0);

    // Abort after five strobes
    setup(20'h40, 20'h3FF, 0);
    start_cap();
    drive(5, 1);
    stop_cap();
    chk("abort_n", q_addr.size(), 1);
    if (q_addr.size() == 1) begin
      chk("abort_a", q_addr[0], 2);
      chk("abort_d", q_din[0], 32'h0000_001F);
    end
    chk("abort_done", done_seen, 0);
    chk("abort_readback", 32'(bus.o_gpio_addr_readback), 32'h40);

    // Random runs, checked by the model every cycle
    for (int it = 0; it < 40; it++) begin
      s = ($urandom_range(0, 2) == 0) ? 20'(20'hFFFE0 - 32 * $urandom_range(0, 2))
                                      : 20'($urandom);
      e = 20'((s / 32) * 32 + $urandom_range(0, 120));
      lp = ($urandom_range(0, 3) == 0);
      setup(s, e, lp);
      start_cap();
      for (int c = 0; c < 200; c++) begin
        if (bus.o_gpio_capture_done) break;
        if ($urandom_range(0, 99) == 0) break;
        bus.i_sample_strobe = ($urandom_range(0, 3) != 0);
        bus.ch_in = 1'($urandom);
        bus.i_gpio_write_addr = ($urandom_range(0, 7) == 0);
        bus.i_gpio_write_stop_addr = ($urandom_range(0, 7) == 0);
        bus.i_gpio_set_ram_addr = 20'($urandom);
        bus.i_gpio_stop_addr = 20'($urandom);
        @(negedge clk);
      end
      bus.i_sample_strobe = 0;
      bus.i_gpio_write_addr = 0;
      bus.i_gpio_write_stop_addr = 0;
      stop_cap();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
